// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, state
// encoding and instruction field slices.
package cpu_pkg;

    localparam int unsigned NREG = 16;
    localparam int unsigned OPW  = 5;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01000;
    localparam logic [OPW-1:0] OP_ROR  = 5'b01001;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01010;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10010;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        StIdle,
        StT0,
        StT1,
        StT2,
        StT3,
        StT4,
        StT5,
        StT6,
        StHalt,
        StWait
    } state_e;

    function automatic logic [OPW-1:0] ir_op(input logic [31:0] ir);
        return ir[31:27];
    endfunction

    function automatic logic [3:0] ir_ra(input logic [31:0] ir);
        return ir[26:23];
    endfunction

    function automatic logic [3:0] ir_rb(input logic [31:0] ir);
        return ir[22:19];
    endfunction

    function automatic logic [3:0] ir_rc(input logic [31:0] ir);
        return ir[18:15];
    endfunction

    // Two-source ALU ops: second operand comes from Rc in T4.
    function automatic logic is_three_op(input logic [OPW-1:0] op);
        return (op >= OP_ADD) && (op <= OP_ROL);
    endfunction

    function automatic logic is_unary(input logic [OPW-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

    function automatic logic is_muldiv(input logic [OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/reg_sel_4to16.sv
// 4-bit register field plus enable to one-hot register select.
module reg_sel_4to16 #(
    parameter int unsigned NOut = 16
) (
    input  logic [3:0]      i_sel,
    input  logic            i_en,
    output logic [NOut-1:0] o_onehot
);

    // Decode the field; all-zero when disabled.
    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired control sequencer: fetch (T0..T2), decode (T3), execute (T4..T6).
// Optional build macro CU_SINGLE_STEP_EN adds an i_step input and a WAIT state
// that holds the sequencer before each new instruction fetch.
module control_unit
    import cpu_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset,
`ifdef CU_SINGLE_STEP_EN
    input  logic            i_step,
`endif
    input  logic [31:0]     i_ir_q,
    output logic            o_pcout,
    output logic            o_pcin,
    output logic            o_incpc,
    output logic            o_marin,
    output logic            o_read,
    output logic            o_mdrin,
    output logic            o_mdrout,
    output logic            o_irin,
    output logic            o_yin,
    output logic            o_zin,
    output logic            o_zhighout,
    output logic            o_zlowout,
    output logic            o_hiin,
    output logic            o_loin,
    output logic            o_hiout,
    output logic            o_loout,
    output logic [OPW-1:0]  o_alu_op,
    output logic [NREG-1:0] o_rin,
    output logic [NREG-1:0] o_rout,
    output logic            o_run,
    output logic            o_illegal
);

    state_e         r_state;
    state_e         w_state_next;
    state_e         w_fetch_state;
    logic [OPW-1:0] w_op;
    logic           w_op_valid;
    logic [3:0]     w_rin_field;
    logic           w_rin_en;
    logic [3:0]     w_rout_field;
    logic           w_rout_en;
    logic           w_unused_ir;

    assign w_op        = ir_op(i_ir_q);
    assign w_op_valid  = is_three_op(w_op) || is_unary(w_op) || is_muldiv(w_op) ||
                         (w_op == OP_NOP) || (w_op == OP_HALT);
    assign w_unused_ir = ^i_ir_q[14:0];

    // Instruction-boundary target: WAIT when single-stepping, otherwise straight to fetch.
`ifdef CU_SINGLE_STEP_EN
    assign w_fetch_state = StWait;
`else
    assign w_fetch_state = StT0;
`endif

    // State register with synchronous reset that overrides any in-flight instruction.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state sequencing.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: w_state_next = StT0;
            StT0:   w_state_next = StT1;
            StT1:   w_state_next = StT2;
            StT2:   w_state_next = StT3;
            StT3: begin
                if (w_op == OP_HALT) begin
                    w_state_next = StHalt;
                end else if (!w_op_valid || (w_op == OP_NOP)) begin
                    w_state_next = w_fetch_state;
                end else begin
                    w_state_next = StT4;
                end
            end
            StT4:   w_state_next = StT5;
            StT5:   w_state_next = is_muldiv(w_op) ? StT6 : w_fetch_state;
            StT6:   w_state_next = w_fetch_state;
            StHalt: w_state_next = StHalt;
`ifdef CU_SINGLE_STEP_EN
            StWait: w_state_next = i_step ? StT0 : StWait;
`else
            StWait: w_state_next = StT0;
`endif
            default: w_state_next = StIdle;
        endcase
    end

    // Moore output decode from state and the current instruction fields.
    always_comb begin
        o_pcout      = 1'b0;
        o_pcin       = 1'b0;
        o_incpc      = 1'b0;
        o_marin      = 1'b0;
        o_read       = 1'b0;
        o_mdrin      = 1'b0;
        o_mdrout     = 1'b0;
        o_irin       = 1'b0;
        o_yin        = 1'b0;
        o_zin        = 1'b0;
        o_zhighout   = 1'b0;
        o_zlowout    = 1'b0;
        o_hiin       = 1'b0;
        o_loin       = 1'b0;
        o_alu_op     = '0;
        o_run        = 1'b1;
        o_illegal    = 1'b0;
        w_rin_field  = 4'd0;
        w_rin_en     = 1'b0;
        w_rout_field = 4'd0;
        w_rout_en    = 1'b0;
        unique case (r_state)
            StT0: begin
                o_pcout = 1'b1;
                o_marin = 1'b1;
                o_incpc = 1'b1;
                o_pcin  = 1'b1;
            end
            StT1: begin
                o_read  = 1'b1;
                o_mdrin = 1'b1;
            end
            StT2: begin
                o_mdrout = 1'b1;
                o_irin   = 1'b1;
            end
            StT3: begin
                if (!w_op_valid) begin
                    o_illegal = 1'b1;
                end else if ((w_op != OP_NOP) && (w_op != OP_HALT)) begin
                    // mul/div take their first operand from Ra, everything else from Rb.
                    w_rout_en    = 1'b1;
                    w_rout_field = is_muldiv(w_op) ? ir_ra(i_ir_q) : ir_rb(i_ir_q);
                    o_yin        = 1'b1;
                end
            end
            StT4: begin
                o_alu_op     = w_op;
                o_zin        = 1'b1;
                w_rout_en    = 1'b1;
                w_rout_field = is_three_op(w_op) ? ir_rc(i_ir_q) : ir_rb(i_ir_q);
            end
            StT5: begin
                o_zlowout = 1'b1;
                if (is_muldiv(w_op)) begin
                    o_loin = 1'b1;
                end else begin
                    w_rin_en    = 1'b1;
                    w_rin_field = ir_ra(i_ir_q);
                end
            end
            StT6: begin
                o_zhighout = 1'b1;
                o_hiin     = 1'b1;
            end
            StHalt: o_run = 1'b0;
            default: ;
        endcase
    end

    // HI/LO bus drives are reserved.
    assign o_hiout = 1'b0;
    assign o_loout = 1'b0;

    reg_sel_4to16 #(
        .NOut(NREG)
    ) u_rin_sel (
        .i_sel   (w_rin_field),
        .i_en    (w_rin_en),
        .o_onehot(o_rin)
    );

    reg_sel_4to16 #(
        .NOut(NREG)
    ) u_rout_sel (
        .i_sel   (w_rout_field),
        .i_en    (w_rout_en),
        .o_onehot(o_rout)
    );

endmodule

// File: tb/tb_control_unit.sv
// Table-driven bench for control_unit plus hand sequences for halt, mid-instruction
// reset and (with CU_SINGLE_STEP_EN) single-step hold.
module tb_control_unit;

    logic        clk;
    logic        reset;
    logic        step;
    logic [31:0] ir;
    logic        pcout, pcin, incpc, marin, read, mdrin, mdrout, irin, yin, zin;
    logic        zhighout, zlowout, hiin, loin, hiout, loout;
    logic [4:0]  alu_op;
    logic [15:0] rin, rout;
    logic        run, illegal;
    logic [15:0] strb;

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_en   = 1'b0;

    localparam logic [31:0] IR_AND  = 32'h2891_8000;
    localparam logic [31:0] IR_MUL  = 32'h7918_0000;
    localparam logic [31:0] IR_NOP  = 32'hD000_0000;
    localparam logic [31:0] IR_ILL  = 32'hF800_0000;
    localparam logic [31:0] IR_HALT = 32'hD800_0000;

    // Strobe bit order: pcout pcin incpc marin read mdrin mdrout irin
    //                   yin zin zhighout zlowout hiin loin hiout loout
    localparam logic [15:0] S_NONE   = 16'h0000;
    localparam logic [15:0] S_T0     = 16'hF000;
    localparam logic [15:0] S_T1     = 16'h0C00;
    localparam logic [15:0] S_T2     = 16'h0300;
    localparam logic [15:0] S_YIN    = 16'h0080;
    localparam logic [15:0] S_ZIN    = 16'h0040;
    localparam logic [15:0] S_ZLO    = 16'h0010;
    localparam logic [15:0] S_ZLO_LO = 16'h0014;
    localparam logic [15:0] S_ZHI_HI = 16'h0028;

    assign strb = {pcout, pcin, incpc, marin, read, mdrin, mdrout, irin,
                   yin, zin, zhighout, zlowout, hiin, loin, hiout, loout};

    control_unit dut (
        .i_clk     (clk),
        .i_reset   (reset),
`ifdef CU_SINGLE_STEP_EN
        .i_step    (step),
`endif
        .i_ir_q    (ir),
        .o_pcout   (pcout),
        .o_pcin    (pcin),
        .o_incpc   (incpc),
        .o_marin   (marin),
        .o_read    (read),
        .o_mdrin   (mdrin),
        .o_mdrout  (mdrout),
        .o_irin    (irin),
        .o_yin     (yin),
        .o_zin     (zin),
        .o_zhighout(zhighout),
        .o_zlowout (zlowout),
        .o_hiin    (hiin),
        .o_loin    (loin),
        .o_hiout   (hiout),
        .o_loout   (loout),
        .o_alu_op  (alu_op),
        .o_rin     (rin),
        .o_rout    (rout),
        .o_run     (run),
        .o_illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic [31:0] ir;
        logic [15:0] strb;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  alu;
        logic        run;
        logic        ill;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input logic rst, input logic [31:0] i,
                                input logic [15:0] s, input logic [15:0] ri,
                                input logic [15:0] ro, input logic [4:0] a,
                                input logic rn, input logic il);
        vec_t v;
        v.name = name; v.rst = rst; v.ir = i; v.strb = s; v.rin = ri; v.rout = ro;
        v.alu = a; v.run = rn; v.ill = il;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] s, input logic [15:0] ri,
                         input logic [15:0] ro, input logic [4:0] a, input logic rn,
                         input logic il);
        n_checks++;
        if (strb === s && rin === ri && rout === ro && alu_op === a && run === rn &&
            illegal === il) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got strb=%h rin=%h rout=%h alu=%b run=%b ill=%b, want strb=%h rin=%h rout=%h alu=%b run=%b ill=%b",
                     name, strb, rin, rout, alu_op, run, illegal, s, ri, ro, a, rn, il);
        end
    endtask

    // Per-cycle bus exclusivity and one-hot register selects.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if ($onehot0({pcout, mdrout, zhighout, zlowout, hiout, loout, |rout}) &&
                $onehot0(rin) && $onehot0(rout)) begin
                n_pass++;
            end else begin
                $display("FAIL bus_excl: got strb=%h rin=%h rout=%h, want at most one driver",
                         strb, rin, rout);
            end
        end
    end

    initial begin
        reset = 1'b1;
        step  = 1'b0;
        ir    = IR_AND;

        vecs.push_back(mk("idle",      1, IR_AND,  S_NONE,   16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("and_t0",    0, IR_AND,  S_T0,     16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("and_t1",    0, IR_AND,  S_T1,     16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("and_t2",    0, IR_AND,  S_T2,     16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("and_t3",    0, IR_AND,  S_YIN,    16'h0, 16'h4, 5'h00, 1, 0));
        vecs.push_back(mk("and_t4",    0, IR_AND,  S_ZIN,    16'h0, 16'h8, 5'h05, 1, 0));
        vecs.push_back(mk("and_t5",    0, IR_AND,  S_ZLO,    16'h2, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("and_next",  0, IR_AND,  S_T0,     16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("mul_t1",    0, IR_MUL,  S_T1,     16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("mul_t2",    0, IR_MUL,  S_T2,     16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("mul_t3",    0, IR_MUL,  S_YIN,    16'h0, 16'h4, 5'h00, 1, 0));
        vecs.push_back(mk("mul_t4",    0, IR_MUL,  S_ZIN,    16'h0, 16'h8, 5'h0F, 1, 0));
        vecs.push_back(mk("mul_t5",    0, IR_MUL,  S_ZLO_LO, 16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("mul_t6",    0, IR_MUL,  S_ZHI_HI, 16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("mul_next",  0, IR_MUL,  S_T0,     16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("nop_t1",    0, IR_NOP,  S_T1,     16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("nop_t2",    0, IR_NOP,  S_T2,     16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("nop_t3",    0, IR_NOP,  S_NONE,   16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("nop_next",  0, IR_NOP,  S_T0,     16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("ill_t1",    0, IR_ILL,  S_T1,     16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("ill_t2",    0, IR_ILL,  S_T2,     16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("ill_t3",    0, IR_ILL,  S_NONE,   16'h0, 16'h0, 5'h00, 1, 1));
        vecs.push_back(mk("ill_next",  0, IR_ILL,  S_T0,     16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("halt_t1",   0, IR_HALT, S_T1,     16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("halt_t2",   0, IR_HALT, S_T2,     16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("halt_t3",   0, IR_HALT, S_NONE,   16'h0, 16'h0, 5'h00, 1, 0));
        vecs.push_back(mk("halt_s",    0, IR_HALT, S_NONE,   16'h0, 16'h0, 5'h00, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
`ifdef CU_SINGLE_STEP_EN
            // Instruction boundaries (not the first fetch after reset) park in WAIT first.
            if (vecs[i].strb == S_T0 && i > 0 && !vecs[i-1].rst) begin
                step = 1'b0;
                tick();
                check({vecs[i].name, "_wait"}, S_NONE, 16'h0, 16'h0, 5'h00, 1, 0);
                step = 1'b1;
            end
`endif
            reset = vecs[i].rst;
            ir    = vecs[i].ir;
            tick();
            step  = 1'b0;
            mon_en = 1'b1;
            check(vecs[i].name, vecs[i].strb, vecs[i].rin, vecs[i].rout, vecs[i].alu,
                  vecs[i].run, vecs[i].ill);
        end

        // Halt is sticky and quiet until reset.
        for (int c = 0; c < 20; c++) begin
            tick();
            check("halt_hold", S_NONE, 16'h0, 16'h0, 5'h00, 0, 0);
        end
        reset = 1'b1;
        tick();
        check("halt_reset_idle", S_NONE, 16'h0, 16'h0, 5'h00, 1, 0);
        reset = 1'b0;
        ir    = IR_AND;
        tick();
        check("halt_reset_t0", S_T0, 16'h0, 16'h0, 5'h00, 1, 0);

        // Reset mid-instruction: taken in T4, no Rin pulse follows.
        tick();
        tick();
        tick();
        tick();
        check("rst_mid_t4", S_ZIN, 16'h0, 16'h8, 5'h05, 1, 0);
        reset = 1'b1;
        tick();
        check("rst_mid_idle", S_NONE, 16'h0, 16'h0, 5'h00, 1, 0);
        reset = 1'b0;
        tick();
        check("rst_mid_t0", S_T0, 16'h0, 16'h0, 5'h00, 1, 0);

`ifdef CU_SINGLE_STEP_EN
        // Hold in WAIT after an ALU op until Step.
        for (int c = 0; c < 5; c++) tick();
        check("step_t5", S_ZLO, 16'h2, 16'h0, 5'h00, 1, 0);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("step_wait", S_NONE, 16'h0, 16'h0, 5'h00, 1, 0);
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        check("step_go_t0", S_T0, 16'h0, 16'h0, 5'h00, 1, 0);
`endif

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
